bch_encoder_par: RTL and testbench
==================================

BCH_ENCODER_PAR -- requirements
Module: bch_encoder_par

Interface
REQ-001 SHALL have parameter N, default 15, meaning full codeword length in bits.
REQ-002 SHALL have parameter K, default 11, meaning full message length in bits, 1 <= K < N.
REQ-003 SHALL have parameter BCH_POLYNOM, default 5'b10011, meaning generator polynomial of N-K+1 bits, MSB = x^(N-K).
REQ-004 SHALL have port CLK  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port RESET  in  1  synchronous, active-low reset.
REQ-006 SHALL have port K_SHORT  in  $clog2(K+1)  runtime message length for shortened code.
REQ-007 SHALL have port BYPASS  in  1  1 = pass data through without parity.
REQ-008 SHALL have ports FIFO_IN_DATA in 1, FIFO_IN_RE out 1, FIFO_IN_EMPTY in 1, meaning an input FIFO with read data valid one clock after RE.
REQ-009 SHALL have ports FIFO_OUT_DATA out 1, FIFO_OUT_WE out 1, FIFO_OUT_FULL in 1, meaning an output FIFO that writes on WE.
REQ-010 SHALL have port FIFO_OUT_LAST  out  1  high with the write of the final bit of each codeword.
REQ-011 SHALL have port BUSY  out  1  high whenever the state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, RD_REQ, RD_CAP, WR_DATA, WR_PAR.
REQ-013 IDLE: K_SHORT and BYPASS SHALL be latched at codeword start; K_SHORT of 0 or greater than K SHALL latch as K; the state SHALL move to RD_REQ when FIFO_IN_EMPTY=0.
REQ-014 RD_REQ: FIFO_IN_RE SHALL be 1 for exactly one clock; the next state SHALL be RD_CAP.
REQ-015 RD_CAP: FIFO_IN_DATA SHALL be captured into the hold register.
REQ-016 RD_CAP: the N-K bit LFSR SHALL update as fb = d ^ sr[N-K-1], sr[0] <= fb, sr[i] <= sr[i-1] ^ (fb & BCH_POLYNOM[i]); the next state SHALL be WR_DATA.
REQ-017 WR_DATA: FIFO_OUT_WE SHALL equal !FIFO_OUT_FULL and FIFO_OUT_DATA SHALL equal the hold register; the state SHALL stay in WR_DATA while FIFO_OUT_FULL=1.
REQ-018 WR_DATA: on a write, the data counter SHALL increment; if it reaches the latched K_SHORT, the next state SHALL be WR_PAR (or IDLE if BYPASS), otherwise RD_REQ if FIFO_IN_EMPTY=0, else IDLE-wait without resetting the counter.
REQ-019 WR_PAR: per cycle with FIFO_OUT_FULL=0, WE SHALL be 1, DATA SHALL be sr[N-K-1], and sr SHALL shift left with zero fill; when FULL=1, WE=0 and sr SHALL hold.
REQ-020 After N-K parity writes, the state SHALL be IDLE, and the counters and sr SHALL be zero.
REQ-021 FIFO_OUT_LAST SHALL be 1 on the last parity write, or on the last data write when BYPASS.
REQ-022 A shortened codeword SHALL equal the full code with K-K_SHORT leading zeros omitted: K_SHORT data bits then N-K parity bits, MSB first.
REQ-023 Changes on K_SHORT and BYPASS mid-codeword SHALL be ignored until the next IDLE latch.
REQ-024 The outputs FIFO_IN_RE, FIFO_OUT_WE, FIFO_OUT_DATA and FIFO_OUT_LAST SHALL be combinational decodes of state, zero in any non-writing or non-reading state.
REQ-025 All counters SHALL be at least 1 bit wide, including when N-K=1.
REQ-026 An illegal state encoding SHALL return to IDLE with counters and sr cleared.

Reset
REQ-027 On a clock edge with RESET=0, the block SHALL enter IDLE with sr, the data counter, the parity counter, the hold register and the latched config all zero.
REQ-028 During reset, FIFO_IN_RE, FIFO_OUT_WE, FIFO_OUT_DATA, FIFO_OUT_LAST and BUSY SHALL all be 0.
REQ-029 Reset mid-codeword SHALL abandon the partial codeword with no further writes, and the next codeword SHALL start clean.

Configuration
REQ-030 When BCH_ENC_STATS_EN is defined, the block SHALL have output CW_COUNT [15:0], incremented on each FIFO_OUT_LAST write, wrapping 16'hFFFF->0, and cleared by reset.
REQ-031 When BCH_ENC_STATS_EN is not defined, the port and counter SHALL be absent and the behaviour SHALL otherwise be identical.

Verification
REQ-032 N=7, K=4, poly 1011, data 1,0,0,0 -> out 1,0,0,0,1,0,1, with LAST on the 7th bit.
REQ-033 N=7, K=4, data 1,1,0,1 then 0,0,0,0 back-to-back -> 1,1,0,1,0,0,1 then 0,0,0,0,0,0,0, with the LFSR clean between codewords.
REQ-034 N=15, K=11, poly 10011, data 1 then ten 0s -> parity 1,0,0,1; then K_SHORT=2 (N=7, K=4) with data 1,0 -> out 1,0,1,1,0.
REQ-035 FIFO_OUT_FULL held high 5 clocks during WR_PAR bit 2 -> WE=0 throughout, no bit lost or duplicated, and the parity sequence is unchanged; BYPASS=1 with 4 bits -> 4 writes, no parity, LAST on the 4th.
REQ-036 RESET=0 after 2 data bits, then a full codeword -> no writes after reset, and the correct codeword follows; with BCH_ENC_STATS_EN defined, CW_COUNT counts 1.

Source files
------------

// File: rtl/bch_encoder_par_if.sv
// Bit-serial FIFO handshake bundle between the BCH encoder and its input/output FIFOs.
// The master modport is the encoder side; the slave modport is the FIFO side.
interface bch_encoder_par_if;
  logic FIFO_IN_DATA;
  logic FIFO_IN_RE;
  logic FIFO_IN_EMPTY;
  logic FIFO_OUT_DATA;
  logic FIFO_OUT_WE;
  logic FIFO_OUT_FULL;
  logic FIFO_OUT_LAST;

  modport master (
    input  FIFO_IN_DATA, FIFO_IN_EMPTY, FIFO_OUT_FULL,
    output FIFO_IN_RE, FIFO_OUT_DATA, FIFO_OUT_WE, FIFO_OUT_LAST
  );

  modport slave (
    output FIFO_IN_DATA, FIFO_IN_EMPTY, FIFO_OUT_FULL,
    input  FIFO_IN_RE, FIFO_OUT_DATA, FIFO_OUT_WE, FIFO_OUT_LAST
  );
endinterface

// File: rtl/bch_encoder_par.sv
// Serial systematic BCH encoder (LFSR division) with shortened-code and bypass support.
// Optional BCH_ENC_STATS_EN adds a 16-bit CW_COUNT of completed codewords.
module bch_encoder_par #(
  parameter int N = 15,
  parameter int K = 11,
  parameter logic [N-K:0] BCH_POLYNOM = 5'b10011
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [$clog2(K+1)-1:0]   K_SHORT,
  input  logic                     BYPASS,
  bch_encoder_par_if.master        fifo,
  output logic                     BUSY
`ifdef BCH_ENC_STATS_EN
  ,
  output logic [15:0]              CW_COUNT
`endif
);

  localparam int M  = N - K;
  localparam int KW = ($clog2(K+1) > 0) ? $clog2(K+1) : 1;
  localparam int PW = ($clog2(M+1) > 0) ? $clog2(M+1) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_CAP  = 3'd2,
    WR_DATA = 3'd3,
    WR_PAR  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [M-1:0]    sr_q, sr_d;
  logic [KW-1:0]   dcnt_q, dcnt_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [KW-1:0]   ks_q, ks_d;
  logic            byp_q, byp_d;
  logic            hold_q, hold_d;
  logic            in_re, out_we, out_data, out_last;
  logic            fb;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    dcnt_d   = dcnt_q;
    pcnt_d   = pcnt_q;
    ks_d     = ks_q;
    byp_d    = byp_q;
    hold_d   = hold_q;
    in_re    = 1'b0;
    out_we   = 1'b0;
    out_data = 1'b0;
    out_last = 1'b0;
    fb       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo.FIFO_IN_EMPTY) begin
          state_d = RD_REQ;
          // A non-zero data count means we are resuming a starved codeword: keep its config.
          if (dcnt_q == '0) begin
            ks_d  = (K_SHORT == '0 || K_SHORT > KW'(K)) ? KW'(K) : K_SHORT;
            byp_d = BYPASS;
          end
        end
      end
      RD_REQ: begin
        in_re   = 1'b1;
        state_d = RD_CAP;
      end
      RD_CAP: begin
        hold_d  = fifo.FIFO_IN_DATA;
        fb      = fifo.FIFO_IN_DATA ^ sr_q[M-1];
        sr_d[0] = fb;
        for (int i = 1; i < M; i++) begin
          sr_d[i] = sr_q[i-1] ^ (fb & BCH_POLYNOM[i]);
        end
        state_d = WR_DATA;
      end
      WR_DATA: begin
        out_data = hold_q;
        if (!fifo.FIFO_OUT_FULL) begin
          out_we = 1'b1;
          dcnt_d = dcnt_q + KW'(1);
          if (dcnt_d == ks_q) begin
            dcnt_d = '0;
            if (byp_q) begin
              out_last = 1'b1;
              sr_d     = '0;
              state_d  = IDLE;
            end else begin
              state_d  = WR_PAR;
            end
          end else begin
            state_d = fifo.FIFO_IN_EMPTY ? IDLE : RD_REQ;
          end
        end
      end
      WR_PAR: begin
        out_data = sr_q[M-1];
        if (!fifo.FIFO_OUT_FULL) begin
          out_we = 1'b1;
          sr_d   = sr_q << 1;
          if (pcnt_q == PW'(M-1)) begin
            out_last = 1'b1;
            pcnt_d   = '0;
            sr_d     = '0;
            state_d  = IDLE;
          end else begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        sr_d    = '0;
        dcnt_d  = '0;
        pcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      sr_q    <= '0;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
      ks_q    <= '0;
      byp_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      ks_q    <= ks_d;
      byp_q   <= byp_d;
      hold_q  <= hold_d;
    end
  end

  assign fifo.FIFO_IN_RE    = in_re;
  assign fifo.FIFO_OUT_WE   = out_we;
  assign fifo.FIFO_OUT_DATA = out_data;
  assign fifo.FIFO_OUT_LAST = out_last;
  assign BUSY               = (state_q != IDLE);

`ifdef BCH_ENC_STATS_EN
  logic [15:0] cw_q, cw_d;

  always_comb begin
    cw_d = cw_q;
    if (out_last) cw_d = cw_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) cw_q <= '0;
    else        cw_q <= cw_d;
  end

  assign CW_COUNT = cw_q;
`endif

endmodule

// File: tb/tb_bch_encoder_par.sv
// Bench for bch_encoder_par: a (7,4) and a (15,11) instance driven through queue-backed FIFO models,
// checked against fixed codewords and a polynomial long-division reference.
module tb_bch_encoder_par;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n  = 1'b0;
  logic [2:0] ks7    = '0;
  logic [3:0] ks15   = '0;
  logic       byp7   = 1'b0;
  logic       byp15  = 1'b0;
  logic       busy7, busy15;
  logic       stall7   = 1'b0;
  logic       rfull_en = 1'b0;
  logic       rfull    = 1'b0;
  int         gapmax   = 0;
  int         nvec     = 0;
  int         nerr     = 0;

  logic inq [2][$];
  logic ob  [2][$];
  logic ol  [2][$];

  bch_encoder_par_if if7 ();
  bch_encoder_par_if if15 ();

  assign if7.FIFO_OUT_FULL  = stall7 | (rfull_en & rfull);
  assign if15.FIFO_OUT_FULL = rfull_en & rfull;

`ifdef BCH_ENC_STATS_EN
  logic [15:0] cw7, cw15;
`endif

  bch_encoder_par #(.N(7), .K(4), .BCH_POLYNOM(4'b1011)) dut7 (
    .CLK(clk), .RESET(rst_n), .K_SHORT(ks7), .BYPASS(byp7), .fifo(if7), .BUSY(busy7)
`ifdef BCH_ENC_STATS_EN
    , .CW_COUNT(cw7)
`endif
  );

  bch_encoder_par #(.N(15), .K(11), .BCH_POLYNOM(5'b10011)) dut15 (
    .CLK(clk), .RESET(rst_n), .K_SHORT(ks15), .BYPASS(byp15), .fifo(if15), .BUSY(busy15)
`ifdef BCH_ENC_STATS_EN
    , .CW_COUNT(cw15)
`endif
  );

  // Input FIFO models: data appears one clock after RE.
  always @(posedge clk) begin : fin7
    logic r;
    r = if7.FIFO_IN_RE;
    #1;
    if (r && inq[0].size() > 0) if7.FIFO_IN_DATA = inq[0].pop_front();
    if7.FIFO_IN_EMPTY = (inq[0].size() == 0);
  end

  always @(posedge clk) begin : fin15
    logic r;
    r = if15.FIFO_IN_RE;
    #1;
    if (r && inq[1].size() > 0) if15.FIFO_IN_DATA = inq[1].pop_front();
    if15.FIFO_IN_EMPTY = (inq[1].size() == 0);
  end

  always @(posedge clk) begin
    #2;
    rfull = ($urandom_range(0, 3) == 0);
  end

  always @(negedge clk) begin
    if (if7.FIFO_OUT_WE) begin
      ob[0].push_back(if7.FIFO_OUT_DATA);
      ol[0].push_back(if7.FIFO_OUT_LAST);
    end
    if (if15.FIFO_OUT_WE) begin
      ob[1].push_back(if15.FIFO_OUT_DATA);
      ol[1].push_back(if15.FIFO_OUT_LAST);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic busy_of(input int w);
    return (w != 0) ? busy15 : busy7;
  endfunction

  function automatic int lasts_of(input int w);
    int c = 0;
    foreach (ol[w][i]) if (ol[w][i]) c++;
    return c;
  endfunction

  // Reference: systematic codeword = msg*x^m + (msg*x^m mod g), by long division.
  function automatic void ref_cw(input int w, input logic [31:0] d, input int eff, input logic byp,
                                 output logic [31:0] cw, output int len);
    int m;
    logic [63:0] r, g;
    m = (w != 0) ? 4 : 3;
    g = (w != 0) ? 64'h13 : 64'hB;
    r = 64'(d) << m;
    for (int i = eff + m - 1; i >= m; i--) if (r[i]) r = r ^ (g << (i - m));
    if (byp) begin
      cw  = d;
      len = eff;
    end else begin
      cw  = 32'((64'(d) << m) | (r & ((64'd1 << m) - 64'd1)));
      len = eff + m;
    end
  endfunction

  task automatic set_cfg(input int w, input int ks, input logic byp);
    if (w == 0) begin ks7  = 3'(ks); byp7  = byp; end
    else        begin ks15 = 4'(ks); byp15 = byp; end
  endtask

  task automatic wait_lasts(input int w, input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (lasts_of(w) >= n) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic collect(input int w, output logic [31:0] got, output logic [31:0] lp);
    got = '0;
    lp  = '0;
    foreach (ob[w][i]) begin
      got = {got[30:0], ob[w][i]};
      lp  = {lp[30:0], ol[w][i]};
    end
  endtask

  task automatic run_cw(input int w, input logic [31:0] data, input int ks, input logic byp,
                        input logic [31:0] exp, input int elen, input string nm);
    int kk, eff;
    bit ok;
    logic [31:0] got, lp;
    kk  = (w != 0) ? 11 : 4;
    eff = (ks == 0 || ks > kk) ? kk : ks;
    set_cfg(w, ks, byp);
    ob[w].delete();
    ol[w].delete();
    for (int i = eff - 1; i >= 0; i--) begin
      inq[w].push_back(data[i]);
      if (i == eff - 1) begin
        for (int t = 0; t < 10 && !busy_of(w); t++) step();
        // Mid-codeword config changes must not affect this codeword.
        set_cfg(w, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      end
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) step();
    end
    wait_lasts(w, 1, ok);
    chk({nm, "_done"}, 32'(ok), 32'd1);
    collect(w, got, lp);
    chk({nm, "_bits"}, got, exp);
    chk({nm, "_len"}, 32'(ob[w].size()), 32'(elen));
    chk({nm, "_last"}, lp, 32'd1);
    chk({nm, "_idle"}, 32'(busy_of(w)), 32'd0);
  endtask

  typedef struct {
    int          w;
    logic [31:0] data;
    int          ks;
    logic        byp;
    logic [31:0] exp;
    int          elen;
    string       nm;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit ok;
    int n0, w, ks, kk, eff, len;
    logic byp;
    logic [31:0] d, e, got, lp;

    tbl[0] = '{0, 32'h8,   4,  1'b0, 32'h45,   7,  "h7_1000"};
    tbl[1] = '{0, 32'hD,   4,  1'b0, 32'h69,   7,  "h7_1101"};
    tbl[2] = '{0, 32'h0,   4,  1'b0, 32'h00,   7,  "h7_0000"};
    tbl[3] = '{1, 32'h400, 11, 1'b0, 32'h4009, 15, "h15_msb"};
    tbl[4] = '{0, 32'h2,   2,  1'b0, 32'h16,   5,  "h7_short2"};
    tbl[5] = '{0, 32'hB,   4,  1'b1, 32'hB,    4,  "h7_bypass"};
    tbl[6] = '{0, 32'h1,   0,  1'b0, 32'h0B,   7,  "h7_ks0"};
    tbl[7] = '{0, 32'h2,   7,  1'b0, 32'h16,   7,  "h7_ksbig"};

    repeat (3) step();
    @(negedge clk);
    chk("rst_out7", 32'({if7.FIFO_IN_RE, if7.FIFO_OUT_WE, if7.FIFO_OUT_DATA, if7.FIFO_OUT_LAST, busy7}), 32'd0);
    chk("rst_out15", 32'({if15.FIFO_IN_RE, if15.FIFO_OUT_WE, if15.FIFO_OUT_DATA, if15.FIFO_OUT_LAST, busy15}), 32'd0);
`ifdef BCH_ENC_STATS_EN
    chk("rst_cw7", 32'(cw7), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();

    foreach (tbl[i]) run_cw(tbl[i].w, tbl[i].data, tbl[i].ks, tbl[i].byp, tbl[i].exp, tbl[i].elen, tbl[i].nm);

    // Two codewords back-to-back through one input burst.
    set_cfg(0, 4, 1'b0);
    ob[0].delete(); ol[0].delete();
    foreach (tbl[i]) if (i < 1) begin
      d = 32'hD0;
      for (int b = 7; b >= 0; b--) inq[0].push_back(d[b]);
    end
    wait_lasts(0, 2, ok);
    chk("b2b_done", 32'(ok), 32'd1);
    repeat (3) step();
    collect(0, got, lp);
    chk("b2b_bits", got, 32'h3480);
    chk("b2b_last", lp, 32'h81);

    // Output FIFO full for 5 clocks with two parity bits written.
    set_cfg(0, 4, 1'b0);
    ob[0].delete(); ol[0].delete();
    d = 32'h8;
    for (int b = 3; b >= 0; b--) inq[0].push_back(d[b]);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (ob[0].size() >= 6) begin ok = 1'b1; break; end
      step();
    end
    chk("stall_reach", 32'(ok), 32'd1);
    stall7 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_we", 32'(if7.FIFO_OUT_WE), 32'd0);
    end
    step();
    stall7 = 1'b0;
    wait_lasts(0, 1, ok);
    collect(0, got, lp);
    chk("stall_bits", got, 32'h45);
    chk("stall_len", 32'(ob[0].size()), 32'd7);
    chk("stall_last", lp, 32'd1);

    // Reset in the middle of a codeword.
    set_cfg(0, 4, 1'b0);
    ob[0].delete(); ol[0].delete();
    for (int b = 0; b < 4; b++) inq[0].push_back(1'b1);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (ob[0].size() >= 2) begin ok = 1'b1; break; end
      step();
    end
    chk("mrst_reach", 32'(ok), 32'd1);
    rst_n = 1'b0;
    inq[0].delete();
    step();
    n0 = ob[0].size();
    @(negedge clk);
    chk("mrst_out", 32'({if7.FIFO_IN_RE, if7.FIFO_OUT_WE, if7.FIFO_OUT_DATA, if7.FIFO_OUT_LAST, busy7}), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("mrst_nowr", 32'(ob[0].size()), 32'(n0));
    run_cw(0, 32'hD, 4, 1'b0, 32'h69, 7, "mrst_next");
`ifdef BCH_ENC_STATS_EN
    chk("cw_count", 32'(cw7), 32'd1);
`endif

    // Randomised codewords with input gaps and output back-pressure.
    gapmax   = 2;
    rfull_en = 1'b1;
    for (int it = 0; it < 30; it++) begin
      w   = $urandom_range(0, 1);
      kk  = (w != 0) ? 11 : 4;
      ks  = $urandom_range(0, (w != 0) ? 15 : 7);
      eff = (ks == 0 || ks > kk) ? kk : ks;
      byp = ($urandom_range(0, 4) == 0);
      d   = $urandom & ((32'd1 << eff) - 32'd1);
      ref_cw(w, d, eff, byp, e, len);
      run_cw(w, d, ks, byp, e, len, "rnd");
    end
    rfull_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
